// File: rtl/alu_dec_pipe_if.sv
// Entry/exit handshake and payload bundle for the pipelined ALU control decoder.
// slave is the decoder's view, master is the producer/consumer side.
interface alu_dec_pipe_if #(
  parameter int TAG_W = 8,
  parameter int CNT_W = 16
);
  logic             in_valid;
  logic             in_ready;
  logic             opb5;
  logic [2:0]       funct3;
  logic             funct7b5;
  logic             funct7b0;
  logic [1:0]       ALUOp;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [4:0]       ALUControl;
  logic             illegal;
  logic [TAG_W-1:0] out_tag;
  logic [CNT_W-1:0] illegal_cnt;

  modport slave (
    input  in_valid, opb5, funct3, funct7b5, funct7b0, ALUOp, in_tag, out_ready,
    output in_ready, out_valid, ALUControl, illegal, out_tag, illegal_cnt
  );

  modport master (
    output in_valid, opb5, funct3, funct7b5, funct7b0, ALUOp, in_tag, out_ready,
    input  in_ready, out_valid, ALUControl, illegal, out_tag, illegal_cnt
  );
endinterface

// File: rtl/alu_dec_pipe.sv
// Pipelined RV32 ALU control decoder with backpressure, flush, RV32M decode,
// illegal-op flagging and a saturating count of accepted illegal entries.
module alu_dec_pipe #(
  parameter int STAGES = 2,
  parameter int TAG_W  = 8,
  parameter bit EN_M   = 1'b1,
  parameter int CNT_W  = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          flush,
  alu_dec_pipe_if.slave bus
);
  localparam logic [4:0] OP_ADD  = 5'b00000;
  localparam logic [4:0] OP_SUB  = 5'b00001;
  localparam logic [4:0] OP_AND  = 5'b00010;
  localparam logic [4:0] OP_OR   = 5'b00011;
  localparam logic [4:0] OP_XOR  = 5'b00100;
  localparam logic [4:0] OP_SLT  = 5'b00101;
  localparam logic [4:0] OP_SLTU = 5'b00110;
  localparam logic [4:0] OP_SLL  = 5'b00111;
  localparam logic [4:0] OP_SRL  = 5'b01000;
  localparam logic [4:0] OP_SRA  = 5'b01001;

  typedef struct packed {
    logic [4:0]       ctl;
    logic             ill;
    logic [TAG_W-1:0] tag;
  } ent_t;

  ent_t              ent_d;
  ent_t              ent_q [STAGES];
  logic [STAGES-1:0] vld_q;
  logic [STAGES-1:0] go;
  logic              acc;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  always_comb begin
    ent_d     = '0;
    ent_d.tag = bus.in_tag;
    ent_d.ctl = OP_ADD;
    unique case (bus.ALUOp)
      2'b00: ent_d.ctl = OP_ADD;
      2'b01: begin
        unique case (bus.funct3[2:1])
          2'b00:   ent_d.ctl = OP_SUB;
          2'b10:   ent_d.ctl = OP_SLT;
          2'b11:   ent_d.ctl = OP_SLTU;
          default: ent_d.ill = 1'b1;
        endcase
      end
      2'b10: begin
        if (bus.opb5 && bus.funct7b0) begin
          // M-extension encodings map straight onto 10_funct3
          if (!EN_M || bus.funct7b5) ent_d.ill = 1'b1;
          else                       ent_d.ctl = {2'b10, bus.funct3};
        end else begin
          unique case (bus.funct3)
            3'b000:  ent_d.ctl = (bus.opb5 && bus.funct7b5) ? OP_SUB : OP_ADD;
            3'b001:  ent_d.ctl = OP_SLL;
            3'b010:  ent_d.ctl = OP_SLT;
            3'b011:  ent_d.ctl = OP_SLTU;
            3'b100:  ent_d.ctl = OP_XOR;
            3'b101:  ent_d.ctl = bus.funct7b5 ? OP_SRA : OP_SRL;
            3'b110:  ent_d.ctl = OP_OR;
            default: ent_d.ctl = OP_AND;
          endcase
        end
      end
      default: ent_d.ill = 1'b1;
    endcase
    if (ent_d.ill) ent_d.ctl = OP_ADD;
  end

  // go[i]: the slot after stage i can take an entry this cycle
  always_comb begin
    go = '0;
    go[STAGES-1] = bus.out_ready;
    for (int i = STAGES - 2; i >= 0; i--) go[i] = !vld_q[i+1] || go[i+1];
  end

  assign bus.in_ready = !reset && !flush && (!vld_q[0] || go[0]);
  assign acc          = bus.in_valid && bus.in_ready;

  always_comb begin
    cnt_d = cnt_q;
    if (acc && ent_d.ill && (cnt_q != {CNT_W{1'b1}})) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      vld_q <= '0;
      for (int i = 0; i < STAGES; i++) ent_q[i] <= '0;
      cnt_q <= '0;
    end else begin
      if (flush) begin
        vld_q <= '0;
      end else begin
        if (!vld_q[0] || go[0]) vld_q[0] <= bus.in_valid;
        for (int i = 1; i < STAGES; i++)
          if (go[i-1]) vld_q[i] <= vld_q[i-1];
      end
      if (acc) ent_q[0] <= ent_d;
      for (int i = 1; i < STAGES; i++)
        if (!flush && vld_q[i-1] && go[i-1]) ent_q[i] <= ent_q[i-1];
      cnt_q <= cnt_d;
    end
  end

  assign bus.out_valid   = vld_q[STAGES-1];
  assign bus.ALUControl  = ent_q[STAGES-1].ctl;
  assign bus.illegal     = ent_q[STAGES-1].ill;
  assign bus.out_tag     = ent_q[STAGES-1].tag;
  assign bus.illegal_cnt = cnt_q;
endmodule

// File: tb/tb_alu_dec_pipe.sv
// Directed bench for alu_dec_pipe: vector table, backpressure, flush, counter
// saturation, full input sweep against a reference decoder, and mid-stream reset.
module tb_alu_dec_pipe;
  logic clk, reset, flush;
  int   total = 0, bad = 0;

  alu_dec_pipe_if #(.TAG_W(8), .CNT_W(16)) ia ();
  alu_dec_pipe_if #(.TAG_W(8), .CNT_W(4))  ib ();

  alu_dec_pipe #(.STAGES(2), .TAG_W(8), .EN_M(1'b1), .CNT_W(16)) dut_a (
    .clk(clk), .reset(reset), .flush(flush), .bus(ia));
  alu_dec_pipe #(.STAGES(2), .TAG_W(8), .EN_M(1'b0), .CNT_W(4)) dut_b (
    .clk(clk), .reset(reset), .flush(flush), .bus(ib));

  // second decoder (no M, 4-bit counter) sees exactly the same stimulus
  assign ib.in_valid  = ia.in_valid;
  assign ib.opb5      = ia.opb5;
  assign ib.funct3    = ia.funct3;
  assign ib.funct7b5  = ia.funct7b5;
  assign ib.funct7b0  = ia.funct7b0;
  assign ib.ALUOp     = ia.ALUOp;
  assign ib.in_tag    = ia.in_tag;
  assign ib.out_ready = ia.out_ready;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [1:0] op;
    logic       ob5;
    logic [2:0] f3;
    logic       f7b5;
    logic       f7b0;
    logic [4:0] ctl1;
    logic       ill1;
    logic [4:0] ctl0;
    logic       ill0;
  } vec_t;

  vec_t tbl [20];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // reference decoder: {illegal, ALUControl}
  function automatic logic [5:0] model(input logic [1:0] op, input logic ob5,
      input logic [2:0] f3, input logic f7b5, input logic f7b0, input bit en_m);
    logic [4:0] br [4];
    logic [4:0] rt [8];
    logic [5:0] v;
    br = '{5'b00001, 5'b11111, 5'b00101, 5'b00110};
    rt = '{5'b00000, 5'b00111, 5'b00101, 5'b00110, 5'b00100, 5'b01000, 5'b00011, 5'b00010};
    if (op == 2'b00) return 6'b000000;
    if (op == 2'b11) return 6'b100000;
    if (op == 2'b01) begin
      if (br[f3[2:1]] == 5'b11111) return 6'b100000;
      return {1'b0, br[f3[2:1]]};
    end
    if (ob5 && f7b0) return (en_m && !f7b5) ? {3'b010, f3} : 6'b100000;
    v = {1'b0, rt[f3]};
    if (f3 == 3'd0 && ob5 && f7b5) v = 6'b000001;
    if (f3 == 3'd5 && f7b5)        v = 6'b001001;
    return v;
  endfunction

  task automatic drive(input logic [1:0] op, input logic ob5, input logic [2:0] f3,
      input logic f7b5, input logic f7b0, input logic [7:0] tag);
    ia.in_valid = 1'b1; ia.ALUOp = op; ia.opb5 = ob5; ia.funct3 = f3;
    ia.funct7b5 = f7b5; ia.funct7b0 = f7b0; ia.in_tag = tag;
  endtask

  task automatic send_one(input int i);
    @(negedge clk);
    drive(tbl[i].op, tbl[i].ob5, tbl[i].f3, tbl[i].f7b5, tbl[i].f7b0, 8'(i + 5));
    #1 chk($sformatf("v%0d_in_ready", i), ia.in_ready, 1);
    @(negedge clk);
    ia.in_valid = 1'b0;
    chk($sformatf("v%0d_lat1_valid", i), ia.out_valid, 0);
    @(negedge clk);
    chk($sformatf("v%0d_lat2_valid", i), ia.out_valid, 1);
    chk($sformatf("v%0d_ctl", i),        ia.ALUControl, tbl[i].ctl1);
    chk($sformatf("v%0d_ill", i),        ia.illegal, tbl[i].ill1);
    chk($sformatf("v%0d_tag", i),        ia.out_tag, 8'(i + 5));
    chk($sformatf("v%0d_b_valid", i),    ib.out_valid, 1);
    chk($sformatf("v%0d_b_ctl", i),      ib.ALUControl, tbl[i].ctl0);
    chk($sformatf("v%0d_b_ill", i),      ib.illegal, tbl[i].ill0);
  endtask

  initial begin
    logic [13:0] qa[$], qb[$];
    logic [13:0] exp_e, prev_e;
    logic [15:0] cnt0;
    logic [7:0]  c;
    logic [5:0]  m;
    int n, cyc, idx, n_ill;
    bit stall_a;

    tbl[0]  = '{2'b10, 1'b1, 3'b000, 1'b1, 1'b0, 5'b00001, 1'b0, 5'b00001, 1'b0};
    tbl[1]  = '{2'b10, 1'b1, 3'b100, 1'b0, 1'b1, 5'b10100, 1'b0, 5'b00000, 1'b1};
    tbl[2]  = '{2'b00, 1'b0, 3'b111, 1'b1, 1'b1, 5'b00000, 1'b0, 5'b00000, 1'b0};
    tbl[3]  = '{2'b01, 1'b0, 3'b001, 1'b0, 1'b0, 5'b00001, 1'b0, 5'b00001, 1'b0};
    tbl[4]  = '{2'b01, 1'b0, 3'b010, 1'b0, 1'b0, 5'b00000, 1'b1, 5'b00000, 1'b1};
    tbl[5]  = '{2'b01, 1'b0, 3'b101, 1'b0, 1'b0, 5'b00101, 1'b0, 5'b00101, 1'b0};
    tbl[6]  = '{2'b01, 1'b0, 3'b110, 1'b0, 1'b0, 5'b00110, 1'b0, 5'b00110, 1'b0};
    tbl[7]  = '{2'b10, 1'b0, 3'b000, 1'b1, 1'b0, 5'b00000, 1'b0, 5'b00000, 1'b0};
    tbl[8]  = '{2'b10, 1'b1, 3'b101, 1'b1, 1'b0, 5'b01001, 1'b0, 5'b01001, 1'b0};
    tbl[9]  = '{2'b10, 1'b0, 3'b101, 1'b0, 1'b0, 5'b01000, 1'b0, 5'b01000, 1'b0};
    tbl[10] = '{2'b10, 1'b1, 3'b001, 1'b0, 1'b0, 5'b00111, 1'b0, 5'b00111, 1'b0};
    tbl[11] = '{2'b10, 1'b1, 3'b111, 1'b0, 1'b0, 5'b00010, 1'b0, 5'b00010, 1'b0};
    tbl[12] = '{2'b10, 1'b1, 3'b110, 1'b0, 1'b0, 5'b00011, 1'b0, 5'b00011, 1'b0};
    tbl[13] = '{2'b10, 1'b1, 3'b100, 1'b0, 1'b0, 5'b00100, 1'b0, 5'b00100, 1'b0};
    tbl[14] = '{2'b10, 1'b1, 3'b011, 1'b0, 1'b0, 5'b00110, 1'b0, 5'b00110, 1'b0};
    tbl[15] = '{2'b10, 1'b1, 3'b010, 1'b0, 1'b0, 5'b00101, 1'b0, 5'b00101, 1'b0};
    tbl[16] = '{2'b10, 1'b1, 3'b000, 1'b1, 1'b1, 5'b00000, 1'b1, 5'b00000, 1'b1};
    tbl[17] = '{2'b11, 1'b1, 3'b000, 1'b0, 1'b0, 5'b00000, 1'b1, 5'b00000, 1'b1};
    tbl[18] = '{2'b10, 1'b1, 3'b111, 1'b0, 1'b1, 5'b10111, 1'b0, 5'b00000, 1'b1};
    tbl[19] = '{2'b10, 1'b0, 3'b000, 1'b0, 1'b1, 5'b00000, 1'b0, 5'b00000, 1'b0};

    reset = 1'b1; flush = 1'b0; ia.out_ready = 1'b1;
    drive(2'b00, 1'b0, 3'b000, 1'b0, 1'b0, 8'd0);
    ia.in_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", ia.in_ready, 0);
    chk("rst_out_valid", ia.out_valid, 0);
    chk("rst_ctl", ia.ALUControl, 0);
    chk("rst_ill", ia.illegal, 0);
    chk("rst_tag", ia.out_tag, 0);
    chk("rst_cnt", ia.illegal_cnt, 0);
    reset = 1'b0;
    #1 chk("post_rst_in_ready", ia.in_ready, 1);

    for (int i = 0; i < 20; i++) send_one(i);
    @(negedge clk);
    chk("tbl_cnt_a", ia.illegal_cnt, 3);
    chk("tbl_cnt_b", ib.illegal_cnt, 5);

    // backpressure: only two slots, order kept, head held stable
    n = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      ia.out_ready = 1'b0;
      drive(2'b00, 1'b0, 3'b000, 1'b0, 1'b0, 8'(100 + n));
      #1 if (ia.in_ready) n++;
    end
    @(negedge clk);
    ia.in_valid = 1'b0;
    #1;
    chk("bp_accepted", n, 2);
    chk("bp_in_ready", ia.in_ready, 0);
    chk("bp_hold_valid", ia.out_valid, 1);
    chk("bp_hold_tag", ia.out_tag, 100);
    ia.out_ready = 1'b1;
    @(negedge clk);
    chk("bp_second_valid", ia.out_valid, 1);
    chk("bp_second_tag", ia.out_tag, 101);
    @(negedge clk);
    chk("bp_drained", ia.out_valid, 0);

    // flush with full pipe: dropped entries never surface, counter untouched
    @(negedge clk);
    ia.out_ready = 1'b0;
    drive(2'b00, 1'b0, 3'b000, 1'b0, 1'b0, 8'd50);
    @(negedge clk);
    ia.in_tag = 8'd51;
    @(negedge clk);
    cnt0 = ia.illegal_cnt;
    drive(2'b11, 1'b0, 3'b000, 1'b0, 1'b0, 8'd52);
    flush = 1'b1;
    #1;
    chk("fl_in_ready", ia.in_ready, 0);
    chk("fl_full", ia.out_valid, 1);
    @(negedge clk);
    flush = 1'b0; ia.in_valid = 1'b0; ia.out_ready = 1'b1;
    chk("fl_out_valid", ia.out_valid, 0);
    chk("fl_cnt_a", ia.illegal_cnt, 32'(cnt0));
    chk("fl_cnt_b", ib.illegal_cnt, 5);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("fl_no_ghost", ia.out_valid, 0);
    end

    // back-to-back illegal stream: full throughput, 4-bit counter saturates
    cnt0 = ia.illegal_cnt;
    n = 0; cyc = 0;
    while (n < 20 && cyc < 100) begin
      @(negedge clk);
      drive(2'b11, 1'b0, 3'b000, 1'b0, 1'b0, 8'(n));
      #1 if (ia.in_ready) n++;
      cyc++;
    end
    @(negedge clk);
    ia.in_valid = 1'b0;
    chk("sat_accepted", n, 20);
    chk("sat_cycles", cyc, 20);
    chk("sat_cnt_b", ib.illegal_cnt, 15);
    chk("sat_cnt_a", ia.illegal_cnt, 32'(cnt0) + 20);
    repeat (3) @(negedge clk);

    // sweep every input combination with random backpressure
    cnt0 = ia.illegal_cnt;
    n_ill = 0; idx = 0; cyc = 0; stall_a = 1'b0; prev_e = '0;
    while ((idx < 256 || qa.size() != 0 || qb.size() != 0) && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      if (stall_a) begin
        chk("sw_hold_valid", ia.out_valid, 1);
        chk("sw_hold_data", {ia.illegal, ia.ALUControl, ia.out_tag}, prev_e);
      end
      ia.out_ready = ($urandom_range(0, 3) != 0);
      if (ia.out_valid && ia.out_ready) begin
        if (qa.size() == 0) chk("sw_a_unexpected", 1, 0);
        else begin
          exp_e = qa.pop_front();
          chk("sw_a_entry", {ia.illegal, ia.ALUControl, ia.out_tag}, exp_e);
        end
      end
      if (ib.out_valid && ib.out_ready) begin
        if (qb.size() == 0) chk("sw_b_unexpected", 1, 0);
        else begin
          exp_e = qb.pop_front();
          chk("sw_b_entry", {ib.illegal, ib.ALUControl, ib.out_tag}, exp_e);
        end
      end
      stall_a = ia.out_valid && !ia.out_ready;
      prev_e  = {ia.illegal, ia.ALUControl, ia.out_tag};
      if (idx < 256) begin
        c = 8'(idx);
        drive(c[7:6], c[5], c[4:2], c[1], c[0], c);
      end else ia.in_valid = 1'b0;
      #1;
      if (ia.in_valid && ia.in_ready) begin
        m = model(c[7:6], c[5], c[4:2], c[1], c[0], 1'b1);
        qa.push_back({m, c});
        n_ill += m[5];
        idx++;
      end
      if (ia.in_valid && ib.in_ready)
        qb.push_back({model(c[7:6], c[5], c[4:2], c[1], c[0], 1'b0), c});
    end
    chk("sw_finished", (cyc < 3000), 1);
    @(negedge clk);
    ia.in_valid = 1'b0;
    chk("sw_cnt_a", ia.illegal_cnt, 32'(cnt0) + 32'(n_ill));
    chk("sw_cnt_b", ib.illegal_cnt, 15);

    // reset mid-stream with flush also asserted
    ia.out_ready = 1'b0;
    drive(2'b10, 1'b1, 3'b000, 1'b1, 1'b0, 8'd77);
    repeat (2) @(negedge clk);
    chk("mr_full", ia.out_valid, 1);
    reset = 1'b1; flush = 1'b1;
    #1 chk("mr_in_ready", ia.in_ready, 0);
    @(negedge clk);
    chk("mr_out_valid", ia.out_valid, 0);
    chk("mr_ctl", ia.ALUControl, 0);
    chk("mr_ill", ia.illegal, 0);
    chk("mr_tag", ia.out_tag, 0);
    chk("mr_cnt_a", ia.illegal_cnt, 0);
    chk("mr_cnt_b", ib.illegal_cnt, 0);
    chk("mr_b_valid", ib.out_valid, 0);
    reset = 1'b0; flush = 1'b0; ia.in_valid = 1'b0; ia.out_ready = 1'b1;
    #1 chk("mr_in_ready_after", ia.in_ready, 1);
    @(negedge clk);
    chk("mr_stays_empty", ia.out_valid, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
